// File: rtl/gray_cnt_sched.sv
// Round-robin owner of one shared 3-bit gray step counter.
// Sequences counter Reset/En per request and returns gray/overflow.
module gray_cnt_sched #(
  parameter int NREQ  = 2,
  parameter int STEPW = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*STEPW-1:0] req_steps,
  input  logic [NREQ-1:0]       req_clear,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  cnt_reset,
  output logic                  cnt_en,
  input  logic [2:0]            cnt_gray,
  input  logic                  cnt_ovf,
  output logic [2:0]            result_gray,
  output logic                  result_ovf
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       own_q, own_d;
  logic [STEPW-1:0] steps_q, steps_d;
  logic             clr_q, clr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [2:0]       rg_q, rg_d;
  logic             ro_q, ro_d;

  logic [1:0]            win;
  logic                  hit;
  int                    idx;
  logic [NREQ-1:0]       req_sh;
  logic [NREQ-1:0]       clr_sh;
  logic [NREQ*STEPW-1:0] st_sh;
  logic [STEPW-1:0]      win_steps;
  logic                  win_clr;

  // Circular search starting at the round-robin pointer
  always_comb begin
    win    = '0;
    hit    = 1'b0;
    idx    = 0;
    req_sh = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      req_sh = req >> idx;
      if (!hit && req_sh[0]) begin
        hit = 1'b1;
        win = idx[1:0];
      end
    end
  end

  always_comb begin
    st_sh     = req_steps >> (int'(win) * STEPW);
    win_steps = st_sh[STEPW-1:0];
    clr_sh    = req_clear >> win;
    win_clr   = clr_sh[0];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    steps_d = steps_q;
    clr_d   = clr_q;
    gnt_d   = gnt_q;
    rg_d    = rg_q;
    ro_d    = ro_q;
    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          own_d   = win;
          steps_d = win_steps;
          clr_d   = win_clr;
          gnt_d   = NREQ'(1) << win;
          if (win_clr)              state_d = S_CLR;
          else if (win_steps == '0) state_d = S_SETTLE;
          else                      state_d = S_RUN;
        end
      end
      S_CLR: begin
        state_d = (steps_q == '0) ? S_SETTLE : S_RUN;
      end
      S_RUN: begin
        steps_d = steps_q - STEPW'(1);
        if (steps_q == STEPW'(1)) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        rg_d    = cnt_gray;
        ro_d    = cnt_ovf;
        state_d = S_DONE;
      end
      S_DONE: begin
        gnt_d   = '0;
        ptr_d   = (own_q == 2'(NREQ-1)) ? 2'd0 : own_q + 2'd1;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      steps_q <= '0;
      clr_q   <= 1'b0;
      gnt_q   <= '0;
      rg_q    <= '0;
      ro_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      steps_q <= steps_d;
      clr_q   <= clr_d;
      gnt_q   <= gnt_d;
      rg_q    <= rg_d;
      ro_q    <= ro_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = (state_q == S_DONE) ? gnt_q : '0;
  assign busy        = (state_q != S_IDLE);
  assign cnt_reset   = (state_q == S_CLR);
  assign cnt_en      = (state_q == S_RUN);
  assign result_gray = rg_q;
  assign result_ovf  = ro_q;

endmodule

// File: tb/tb_gray_cnt_sched.sv
// Directed bench for gray_cnt_sched with a behavioural
// 3-bit gray counter (sticky overflow) on its counter port.
module tb_gray_cnt_sched;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] req;
  logic [7:0] req_steps;
  logic [1:0] req_clear;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic       cnt_reset;
  logic       cnt_en;
  logic [2:0] cnt_gray;
  logic       cnt_ovf;
  logic [2:0] result_gray;
  logic       result_ovf;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  gray_cnt_sched #(.NREQ(2), .STEPW(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req        (req),
    .req_steps  (req_steps),
    .req_clear  (req_clear),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .cnt_reset  (cnt_reset),
    .cnt_en     (cnt_en),
    .cnt_gray   (cnt_gray),
    .cnt_ovf    (cnt_ovf),
    .result_gray(result_gray),
    .result_ovf (result_ovf)
  );

  logic [2:0] mb   = 3'd0;
  logic       movf = 1'b0;

  always @(posedge Clk) begin
    if (cnt_reset) begin
      mb   <= 3'd0;
      movf <= 1'b0;
    end else if (cnt_en) begin
      mb <= mb + 3'd1;
      if (mb == 3'd7) movf <= 1'b1;
    end
  end

  assign cnt_gray = mb ^ (mb >> 1);
  assign cnt_ovf  = movf;

  always @(negedge Clk) begin
    if (cnt_reset === 1'b1 && cnt_en === 1'b1) begin
      errors++;
      $error("FAIL rst_en_excl obs=%b%b exp=not both", cnt_reset, cnt_en);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    req   = '0;
    tick();
    tick();
    chk("rst_gnt",  32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cr",   32'(cnt_reset), 0);
    chk("rst_ce",   32'(cnt_en), 0);
    chk("rst_rg",   32'(result_gray), 0);
    chk("rst_ro",   32'(result_ovf), 0);
    Reset = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] rq,
                        input logic [7:0] st, input logic [1:0] cl,
                        input logic [1:0] ed, input int el,
                        input int er, input int ee,
                        input logic [2:0] eg, input logic eo,
                        input bit drop);
    int n, nr, ne;
    bit seen;
    logic [1:0] dv, gv;
    req = rq;
    req_steps = st;
    req_clear = cl;
    n = 0; nr = 0; ne = 0; seen = 0; dv = '0; gv = '0;
    while (!seen && n < 40) begin
      tick();
      n++;
      nr += int'(cnt_reset);
      ne += int'(cnt_en);
      if (drop && ne == 2) req = '0;
      if (done !== 2'b00) begin
        seen = 1;
        dv = done;
        gv = gnt;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 1);
    chk({tag, "_done"}, 32'(dv), 32'(ed));
    chk({tag, "_gnt"},  32'(gv), 32'(ed));
    chk({tag, "_lat"},  32'(n), 32'(el));
    chk({tag, "_nrst"}, 32'(nr), 32'(er));
    chk({tag, "_nen"},  32'(ne), 32'(ee));
    chk({tag, "_rg"},   32'(result_gray), 32'(eg));
    chk({tag, "_ro"},   32'(result_ovf), 32'(eo));
    req = req & ~dv;
    tick();
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_dpul"}, 32'(done), 0);
    chk({tag, "_gdrp"}, 32'(gnt), 0);
    chk({tag, "_hold"}, 32'(result_gray), 32'(eg));
  endtask

  initial begin
    Reset = 1'b1;
    req = '0;
    req_steps = '0;
    req_clear = '0;
    do_reset();

    run_op("t1", 2'b01, 8'h03, 2'b01, 2'b01, 6, 1, 3, 3'b010, 1'b0, 0);
    run_op("t2", 2'b10, 8'h60, 2'b00, 2'b10, 8, 0, 6, 3'b001, 1'b1, 0);

    do_reset();
    run_op("t3a", 2'b11, 8'h11, 2'b11, 2'b01, 4, 1, 1, 3'b001, 1'b0, 0);
    run_op("t3b", 2'b11, 8'h11, 2'b11, 2'b10, 4, 1, 1, 3'b001, 1'b0, 0);
    run_op("t3c", 2'b01, 8'h11, 2'b11, 2'b01, 4, 1, 1, 3'b001, 1'b0, 0);

    run_op("t4", 2'b01, 8'h00, 2'b01, 2'b01, 3, 1, 0, 3'b000, 1'b0, 0);

    req = 2'b01;
    req_steps = 8'h05;
    req_clear = 2'b00;
    tick();
    chk("t5_en1", 32'(cnt_en), 1);
    tick();
    chk("t5_en2", 32'(cnt_en), 1);
    Reset = 1'b1;
    req = '0;
    tick();
    chk("t5_gnt",  32'(gnt), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_en",   32'(cnt_en), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_rg",   32'(result_gray), 0);
    Reset = 1'b0;
    tick();
    run_op("t5a", 2'b11, 8'h22, 2'b11, 2'b01, 5, 1, 2, 3'b011, 1'b0, 0);
    run_op("t5b", 2'b10, 8'h22, 2'b11, 2'b10, 5, 1, 2, 3'b011, 1'b0, 0);

    run_op("t6", 2'b01, 8'h04, 2'b01, 2'b01, 7, 1, 4, 3'b110, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
